// File: rtl/set_button_ctrl.sv
// Front-panel button controller: synchronises and debounces the mode/up/down
// buttons, runs the RUN -> SET_SEC -> SET_MIN -> SET_HOUR mode machine and
// issues active-low one-cycle up/down step pulses with auto-repeat.
// Ports: clk, rst_n (async, active-low); btn_mode_n/btn_up_n/btn_down_n raw
// active-low buttons; sec/min/hour_set_ena one-hot per SET state; up/down
// active-low step pulses; mode_state (00 RUN, 01 SEC, 10 MIN, 11 HOUR).
// Latency: raw press to registered effect is DEB_CYCLES+2 edges; no backpressure.
module set_button_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int REP_DELAY  = 16,
  parameter int REP_PERIOD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode_n,
  input  logic       btn_up_n,
  input  logic       btn_down_n,
  output logic       sec_set_ena,
  output logic       min_set_ena,
  output logic       hour_set_ena,
  output logic       up,
  output logic       down,
  output logic [1:0] mode_state
);

  localparam logic [1:0] ST_RUN  = 2'b00;
  localparam logic [1:0] ST_SEC  = 2'b01;
  localparam logic [1:0] ST_MIN  = 2'b10;
  localparam logic [1:0] ST_HOUR = 2'b11;

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int RW = $clog2(REP_DELAY + 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST   = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] REP_RELOAD = RW'(REP_DELAY - REP_PERIOD);

  // Button vector index: 0 = mode, 1 = up, 2 = down.
  logic [2:0]    raw;
  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    deb_q, deb_d, deb_prev_q;
  logic [2:0]    lock_q, lock_d;
  logic [DW-1:0] cnt_q [3];
  logic [DW-1:0] cnt_d [3];
  logic [1:0]    settle_q;
  logic [1:0]    mode_q, mode_d;
  logic          sec_q, min_q, hour_q;
  logic          up_q, up_d, dn_q, dn_d;
  logic [RW-1:0] rep_q, rep_d;

  logic [2:0] held, fall;
  logic       mode_press, in_set, step_ok;
  logic       up_act, dn_act, rep_due, up_fire, dn_fire;

  assign raw = {btn_down_n, btn_up_n, btn_mode_n};

  // Debounce: the level follows the synchroniser only after DEB_CYCLES
  // consecutive differing samples; any agreeing sample restarts the count.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) deb_d[i] = sync2_q[i];
        else                      cnt_d[i] = cnt_q[i] + DW'(1);
      end
    end
  end

  assign held       = ~deb_q;
  assign fall       = deb_prev_q & ~deb_q;
  assign mode_press = fall[0] & ~lock_q[0];
  assign in_set     = (mode_q != ST_RUN);
  assign step_ok    = in_set & ~mode_press;

  // A step button drives pulses only while it is the sole step button held
  // and not locked out.
  assign up_act  = held[1] & ~lock_q[1] & ~held[2];
  assign dn_act  = held[2] & ~lock_q[2] & ~held[1];
  assign rep_due = (rep_q == REP_LAST);
  assign up_fire = step_ok & up_act & (fall[1] | rep_due);
  assign dn_fire = step_ok & dn_act & (fall[2] | rep_due);

  // Lockout: every button starts locked out of reset so a button held across
  // reset is ignored until it reads released. The sync chain carries stale
  // reset values for two edges, so clearing waits until settle_q[1].
  always_comb begin
    lock_d = lock_q;
    for (int i = 0; i < 3; i++) begin
      if (settle_q[1] && deb_q[i] && sync2_q[i]) lock_d[i] = 1'b0;
    end
    if (held[1] && (held[2] || mode_press)) lock_d[1] = 1'b1;
    if (held[2] && (held[1] || mode_press)) lock_d[2] = 1'b1;
  end

  // Shared repeat counter: zero on the initial press, fires at REP_DELAY-1,
  // then reloads so the next fire is REP_PERIOD cycles later.
  always_comb begin
    rep_d = '0;
    if ((up_act || dn_act) && !mode_press) begin
      if (fall[1] || fall[2]) rep_d = '0;
      else if (rep_due)       rep_d = REP_RELOAD;
      else                    rep_d = rep_q + RW'(1);
    end
  end

  assign mode_d = mode_press ? (mode_q + 2'd1) : mode_q;
  assign up_d   = ~up_fire;
  assign dn_d   = ~dn_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 3'b111;
      sync2_q    <= 3'b111;
      deb_q      <= 3'b111;
      deb_prev_q <= 3'b111;
      lock_q     <= 3'b111;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      settle_q   <= 2'b00;
      mode_q     <= ST_RUN;
      sec_q      <= 1'b0;
      min_q      <= 1'b0;
      hour_q     <= 1'b0;
      up_q       <= 1'b1;
      dn_q       <= 1'b1;
      rep_q      <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      lock_q     <= lock_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      settle_q   <= {settle_q[0], 1'b1};
      mode_q     <= mode_d;
      sec_q      <= (mode_d == ST_SEC);
      min_q      <= (mode_d == ST_MIN);
      hour_q     <= (mode_d == ST_HOUR);
      up_q       <= up_d;
      dn_q       <= dn_d;
      rep_q      <= rep_d;
    end
  end

  assign mode_state   = mode_q;
  assign sec_set_ena  = sec_q;
  assign min_set_ena  = min_q;
  assign hour_set_ena = hour_q;
  assign up           = up_q;
  assign down         = dn_q;

endmodule

// File: doc/set_button_ctrl.md
# set_button_ctrl

Front-panel button controller for the digital clock. Synchronises and debounces three raw active-low push-buttons (mode, up, down), runs the RUN/SET mode state machine, and drives the per-field `set_ena` plus active-low `up`/`down` step pulses consumed by the second, minute and hour counters. It is the source end of the counters' set interface. Held up/down buttons auto-repeat.

## Interface
- `DEB_CYCLES`, 4: consecutive stable synchronised samples required before a debounced level changes (≥2).
- `REP_DELAY`, 16: cycles from the first step pulse to the first auto-repeat pulse.
- `REP_PERIOD`, 4: cycles between subsequent auto-repeat pulses (≥2).
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_mode_n`  in  1  raw mode button; 0 = pressed; asynchronous.
- `btn_up_n`  in  1  raw up button; 0 = pressed; asynchronous.
- `btn_down_n`  in  1  raw down button; 0 = pressed; asynchronous.
- `sec_set_ena`  out  1  1 while in SET_SEC.
- `min_set_ena`  out  1  1 while in SET_MIN.
- `hour_set_ena`  out  1  1 while in SET_HOUR.
- `up`  out  1  active-low step-up pulse; one cycle per step.
- `down`  out  1  active-low step-down pulse; one cycle per step.
- `mode_state`  out  2  current mode: 00 RUN, 01 SET_SEC, 10 SET_MIN, 11 SET_HOUR.

## Operation
- **Reset (rst_n=0, asynchronous):**
  - Mode: RUN, `mode_state`=00.
  - All `*_set_ena`=0; `up`=`down`=1.
  - Synchronisers and debounced levels: 1 (released).
  - Debounce and repeat counters: 0.
- **Input conditioning:** each button passes through a 2-FF synchroniser, then a debouncer.
  - Debounced level copies the synchronised level only after DEB_CYCLES consecutive samples differ from it.
  - Any matching sample clears that button's counter; shorter glitches are ignored.
- **Press event:** debounced 1→0 transition. Release: debounced 0→1. Only press events act.
- **Mode FSM:**
  - A mode press advances RUN→SET_SEC→SET_MIN→SET_HOUR→RUN.
  - Exactly one `*_set_ena` is 1 in each SET state; all are 0 in RUN.
  - `*_set_ena` and `mode_state` are registered and change on the same edge.
- **Step pulses (SET states only):**
  - Up press: `up`=0 for exactly one cycle.
  - Down press: `down`=0 for exactly one cycle.
  - In RUN, `up`/`down` stay 1 regardless of buttons.
- **Auto-repeat:**
  - While the same button stays debounced-pressed, the mode is unchanged, and the other step button is released:
    - first repeat pulse occurs REP_DELAY cycles after the initial pulse;
    - further pulses follow every REP_PERIOD cycles.
  - Release stops repeat immediately and clears the repeat counter.
- **Simultaneous up and down:**
  - Both debounced-pressed, or both pressing on the same edge: no pulses, repeat counter held at 0.
  - After one button releases, the remaining button does not pulse until it is released and pressed again.
- **Mode change while up/down is held:**
  - Repeat stops and the counter clears.
  - The held button is locked out until it is released.
- **Mode press on the same edge as an up/down press:**
  - The mode advances.
  - The step press is discarded.
- `up` and `down` are never 0 in the same cycle.

## Timing
- **Latency:** raw press stable before edge E0 → debounced level changes at edge E0+1+DEB_CYCLES → registered effect at edge E0+2+DEB_CYCLES (`up`/`down` low, or new mode). With DEB_CYCLES=4, that is 6 edges.
- **Release latency:** same path; no output pulse on release.
- **Repeat timing:** with the initial pulse in cycle P, repeats fall in cycles P+REP_DELAY, then P+REP_DELAY+k·REP_PERIOD.
- **Reset mid-pulse:** `up`/`down` return to 1 asynchronously.
  - A button still held after reset deasserts counts as a new press only after its debounced level first reads released; no pulse fires straight out of reset.
- **Clock domain:** one clock; no combinational path from inputs to outputs.

## Test plan
- **Reset:** assert rst_n=0 mid-repeat with up held → `up`=1, `mode_state`=00, all set_ena=0 immediately; after release of reset with up still held, no `up` pulse.
- **Mode cycle:** four clean mode presses (each 10 cycles) → `mode_state` 01,10,11,00; `sec/min/hour_set_ena` one-hot accordingly; each change at press edge +6 (DEB_CYCLES=4).
- **Debounce:** in SET_SEC, 3-cycle up glitch → no pulse; 5-cycle up press → exactly one `up`=0 cycle, 6 edges after press start.
- **Auto-repeat:** in SET_MIN, hold down 40 cycles → pulses at P, P+16, P+20, P+24, …; release stops pulses within one cycle; in RUN the same hold → no pulses.
- **Conflicts:** up and down pressed together in SET_HOUR → no pulses on either output. Mode pressed while up held → mode advances, no further `up` pulse until up is released and re-pressed.
